// File: rtl/sipo_deserializer_pkg.sv
// Shared types and defaults for the serial-in/parallel-out deserializer.
package sipo_deserializer_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [0:0] {
    StShift = 1'b0,
    StFull  = 1'b1
  } state_e;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with synchronous active-low reset, clear and a wrap strobe.
module mod_n_counter #(
  parameter int unsigned N    = 8,
  parameter int unsigned CntW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            clr,
  output logic [CntW-1:0] count,
  output logic            wrap
);

  logic [CntW-1:0] count_q, count_d;
  logic            at_top;

  assign at_top = (count_q == CntW'(N - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = at_top ? '0 : count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Clear suppresses the strobe so a discarded bit never completes a word.
  assign wrap  = inc & ~clr & at_top;
  assign count = count_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Assembles a registered serial bit stream into WIDTH-bit words behind a valid/ready
// output slot, with a one-word park buffer that back-pressures the serial input.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CntW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CntW-1:0]  bit_cnt
);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;

  logic             accept;
  logic             complete;
  logic             slot_free;
  logic [WIDTH-1:0] shift_next;
  logic             load;
  logic [WIDTH-1:0] load_data;

  assign d_ready   = (state_q == StShift);
  assign accept    = d_valid & d_ready;
  assign slot_free = ~out_valid_q | out_ready;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_next = {shreg_q[WIDTH-2:0], d};
    end else begin : g_lsb
      assign shift_next = {d, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  mod_n_counter #(
    .N    (WIDTH),
    .CntW (CntW)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .clr   (clear),
    .count (bit_cnt),
    .wrap  (complete)
  );

  // A completed word goes straight to the slot when it frees up this cycle;
  // otherwise a parked word drains into the slot when the consumer takes the old one.
  always_comb begin
    load      = 1'b0;
    load_data = shreg_q;
    if (complete && slot_free) begin
      load      = 1'b1;
      load_data = shift_next;
    end else if (state_q == StFull && out_ready && !clear) begin
      load      = 1'b1;
      load_data = shreg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StShift;
      shreg_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (load) begin
        out_data_q  <= load_data;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (clear) begin
        shreg_q <= '0;
        state_q <= StShift;
      end else if (accept) begin
        shreg_q <= shift_next;
        if (complete && !slot_free) begin
          state_q <= StFull;
        end
      end else if (state_q == StFull && out_ready) begin
        state_q <= StShift;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_sipo_deserializer;

  logic       clk;
  logic       rst_n;
  logic       d;
  logic       d_valid;
  logic       clear;
  logic       out_ready;

  logic       m_d_ready, l_d_ready;
  logic [7:0] m_out_data, l_out_data;
  logic       m_out_valid, l_out_valid;
  logic [2:0] m_bit_cnt, l_bit_cnt;

  int checks = 0;
  int errors = 0;

  sipo_deserializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1)
  ) u_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .d_valid   (d_valid),
    .d_ready   (m_d_ready),
    .clear     (clear),
    .out_data  (m_out_data),
    .out_valid (m_out_valid),
    .out_ready (out_ready),
    .bit_cnt   (m_bit_cnt)
  );

  sipo_deserializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b0)
  ) u_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .d_valid   (d_valid),
    .d_ready   (l_d_ready),
    .clear     (clear),
    .out_data  (l_out_data),
    .out_valid (l_out_valid),
    .out_ready (out_ready),
    .bit_cnt   (l_bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bits go out w[7] first, back to back; d_valid drops after the last bit.
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      d       = w[i];
      d_valid = 1'b1;
      tick();
    end
    d_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    d         = 1'b1;
    d_valid   = 1'b1;
    clear     = 1'b0;
    out_ready = 1'b0;

    // Reset held with live input
    repeat (3) tick();
    d_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 8'(m_out_valid), 8'h00);
    chk("rst_data",  m_out_data,      8'h00);
    chk("rst_cnt",   8'(m_bit_cnt),   8'h00);
    chk("rst_ready", 8'(m_d_ready),   8'h01);
    chk("rst_lsb_ready", 8'(l_d_ready), 8'h01);

    // Basic word, consumer always ready
    out_ready = 1'b1;
    send_bits(8'hA5, 3);
    chk("mid_cnt", 8'(m_bit_cnt), 8'h03);
    send_bits(8'hA5 << 3, 5);
    chk("basic_data",  m_out_data,      8'hA5);
    chk("basic_valid", 8'(m_out_valid), 8'h01);
    chk("basic_cnt",   8'(m_bit_cnt),   8'h00);
    chk("lsb_pal",     l_out_data,      8'hA5);
    tick();
    chk("basic_drain", 8'(m_out_valid), 8'h00);

    // First bit lands in bit 7 or bit 0 depending on order
    send_bits(8'h80, 8);
    chk("msb_80", m_out_data, 8'h80);
    chk("lsb_01", l_out_data, 8'h01);
    tick();

    // Back-pressure: second word parks, input stalls
    out_ready = 1'b0;
    send_bits(8'h3C, 8);
    chk("bp_first", m_out_data, 8'h3C);
    send_bits(8'hC3, 8);
    chk("bp_ready",     8'(m_d_ready),   8'h00);
    chk("bp_hold",      m_out_data,      8'h3C);
    chk("bp_valid",     8'(m_out_valid), 8'h01);
    chk("bp_lsb_ready", 8'(l_d_ready),   8'h00);
    d       = 1'b1;
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    chk("bp_ignored", 8'(m_bit_cnt), 8'h00);
    chk("bp_stable",  m_out_data,    8'h3C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_second",   m_out_data,      8'hC3);
    chk("bp_valid2",   8'(m_out_valid), 8'h01);
    chk("bp_resume",   8'(m_d_ready),   8'h01);
    chk("bp_lsb_data", l_out_data,      8'hC3);
    out_ready = 1'b1;
    tick();
    chk("bp_empty", 8'(m_out_valid), 8'h00);

    // Clear mid-word; the bit presented with clear is dropped
    send_bits(8'hFF, 5);
    chk("clr_pre", 8'(m_bit_cnt), 8'h05);
    clear   = 1'b1;
    d       = 1'b1;
    d_valid = 1'b1;
    tick();
    clear   = 1'b0;
    d_valid = 1'b0;
    chk("clr_cnt", 8'(m_bit_cnt), 8'h00);
    send_bits(8'h81, 8);
    chk("clr_word", m_out_data, 8'h81);
    tick();

    // Clear while a word is parked
    out_ready = 1'b0;
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    chk("cf_full", 8'(m_d_ready), 8'h00);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("cf_ready", 8'(m_d_ready),   8'h01);
    chk("cf_data",  m_out_data,      8'h11);
    chk("cf_valid", 8'(m_out_valid), 8'h01);
    out_ready = 1'b1;
    tick();
    chk("cf_dropped", 8'(m_out_valid), 8'h00);
    chk("cf_keep",    m_out_data,      8'h11);

    // Reset mid-operation, asserted between edges
    out_ready = 1'b0;
    send_bits(8'h5A, 8);
    send_bits(8'hFF, 3);
    chk("ro_cnt", 8'(m_bit_cnt), 8'h03);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ro_sync_cnt",   8'(m_bit_cnt),   8'h03);
    chk("ro_sync_valid", 8'(m_out_valid), 8'h01);
    tick();
    chk("ro_valid", 8'(m_out_valid), 8'h00);
    chk("ro_data",  m_out_data,      8'h00);
    chk("ro_cnt0",  8'(m_bit_cnt),   8'h00);
    chk("ro_ready", 8'(m_d_ready),   8'h01);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_bits(8'h96, 8);
    chk("ro_word", m_out_data,      8'h96);
    chk("ro_lsb",  l_out_data,      8'h69);
    chk("ro_vld",  8'(m_out_valid), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in/parallel-out stage that sits directly downstream of the single-bit D flip-flop. It consumes the registered serial bit stream (the flip-flop's Q) and assembles WIDTH-bit words. Completed words are presented on a valid/ready output port. A one-word holding buffer decouples assembly from the consumer, and input back-pressure stops bits from being lost.

Parameters:
WIDTH, 8, word length in bits (minimum 2)
MSB_FIRST, 1, 1 = first received bit lands in Out_data[WIDTH-1]; 0 = first bit lands in Out_data[0]

Ports:
Clk  input  1  single clock; all state updates on rising edge
Rst_n  input  1  reset, synchronous, active-low
D  input  1  serial data bit (driven from upstream flip-flop Q)
D_valid  input  1  D carries a bit this cycle
D_ready  output  1  block can accept a bit this cycle
Clear  input  1  synchronous flush of the partially assembled word
Out_data  output  WIDTH  assembled word
Out_valid  output  1  Out_data holds an unconsumed word
Out_ready  input  1  consumer accepts Out_data this cycle
Bit_cnt  output  $clog2(WIDTH)  bits currently held in the assembly register

Behaviour:
- Reset (Rst_n=0 at a rising edge): shreg=0, Bit_cnt=0, Out_data=0, Out_valid=0, state=SHIFT. D_ready=1 from the first cycle after reset. Reset overrides every other input, including mid-word or mid-hold.
- States: SHIFT (assembling) and FULL (complete word parked in shreg, output slot occupied).
- D_ready = (state==SHIFT). It is combinational from state only, with no dependence on Out_ready.
- Accept = D_valid & D_ready.
- On Accept:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], D}.
  - MSB_FIRST=0: shreg <= {D, shreg[WIDTH-1:1]}.
  - Bit_cnt increments.
- Word completion (Accept with Bit_cnt==WIDTH-1):
  - Bit_cnt wraps to 0.
  - Slot free (Out_valid==0 or Out_ready==1): Out_data <= completed word including the current bit; Out_valid <= 1; stay in SHIFT.
  - Slot busy: shreg <= completed word; go to FULL.
- FULL:
  - D_ready=0 and D is ignored.
  - On Out_ready: Out_data <= shreg, Out_valid stays 1, go to SHIFT. The next bit can be accepted in the following cycle.
- Out_valid clears on Out_ready when no new word loads that cycle. Simultaneous drain and load keeps Out_valid=1 with no bubble.
- Latency: the last bit, accepted at edge n, is visible on Out_data/Out_valid after edge n. Sustained throughput is 1 word per WIDTH cycles when Out_ready is held high.
- Out_data is stable while Out_valid=1 and Out_ready=0.
- Clear (priority below Rst_n):
  - Bit_cnt <= 0 and shreg <= 0; any Accept in the same cycle is discarded.
  - In FULL, the parked word is discarded and state goes to SHIFT.
  - Out_data and Out_valid are unaffected.
- D_valid=0 gaps of any length mid-word preserve shreg and Bit_cnt.

Decomposition:
- Shared header sipo_defs.vh holds:
  - state encodings (ST_SHIFT=1'b0, ST_FULL=1'b1)
  - a default-width localparam
- One natural sub-module, mod_n_counter: parameterised modulo-WIDTH counter with inc, clr and synchronous active-low reset, exposing count and a wrap flag. It produces Bit_cnt and the completion strobe.
- Shift register, state register and output slot stay in the top module.

Test Plan:
- Reset: hold Rst_n=0 for 3 cycles with D_valid=1, D=1 → Out_valid=0, Out_data=8'h00, Bit_cnt=0, D_ready=1. Confirm the reset is synchronous by releasing it mid-cycle.
- Basic word (WIDTH=8, MSB_FIRST=1): send 1,0,1,0,0,1,0,1 back-to-back with Out_ready=1 → Out_data=8'hA5 and Out_valid=1 on the cycle after the 8th bit; Out_valid=0 one cycle later.
- LSB-first (MSB_FIRST=0): send the same sequence → Out_data=8'hA5 bit-reversed = 8'hA5 (palindrome check). Then send 1,0,0,0,0,0,0,0 → 8'h01.
- Back-pressure: Out_ready=0, stream 8'h3C then 8'hC3 → D_ready falls after the 16th bit, with Out_data=8'h3C held. Raise Out_ready for 1 cycle → Out_data=8'hC3, D_ready=1; no bits lost.
- Clear mid-word: after 5 bits of 8'hFF, pulse Clear, then send 8'h81 → Bit_cnt=0 after Clear and Out_data=8'h81. Clear while in FULL → parked word dropped and D_ready=1.
- Reset mid-operation: apply Rst_n=0 with 3 bits assembled and Out_valid=1 → all outputs return to reset values. The next full word assembles correctly from bit 0.
